// File: rtl/aes_bus_pkg.sv
// Shared types and constants for the AES128 chip bus sequencer.
// 128-bit vectors are held [127:0]; bit 0 of the chip's [0:127] order is bit 127 here.
package aes_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        WR_KEY,
        WR_MSG,
        START,
        WAIT,
        READ,
        RESP
    } state_t;

    localparam logic ADR_KEY  = 1'b1;
    localparam logic ADR_MSG  = 1'b0;
    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;
    localparam int   WORDS_PER_BLOCK = 4;

    // Word 0 is the most significant 32 bits, matching the chip's load order.
    function automatic logic [31:0] word_sel(input logic [127:0] vec, input logic [1:0] idx);
        logic [31:0] w;
        case (idx)
            2'd0:    w = vec[127:96];
            2'd1:    w = vec[95:64];
            2'd2:    w = vec[63:32];
            default: w = vec[31:0];
        endcase
        return w;
    endfunction

endpackage

// File: rtl/aes_bus_master_aes_word_serializer.sv
// 128-to-32 word selector driven by a wrapping 2-bit word counter.
// last flags the final word of a block so the owner can change state on it.
module aes_word_serializer
    import aes_bus_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [127:0] block,
    output logic [31:0]  word,
    output logic         last
);

    logic [1:0] idx_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            idx_reg <= '0;
        end else if (en) begin
            idx_reg <= idx_reg + 2'd1;
        end
    end

    assign word = word_sel(block, idx_reg);
    assign last = en && (idx_reg == 2'(WORDS_PER_BLOCK - 1));

endmodule

// File: rtl/aes_bus_master.sv
// Host-side sequencer: loads key/block into the AES128 chip over its 32-bit
// word bus, starts the core, waits out its latency and reads the result back.
module aes_bus_master
    import aes_bus_pkg::*;
#(
    parameter int CORE_LAT = 12,
    parameter int READ_LAT = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [127:0] req_key,
    input  logic [127:0] req_msg,
    input  logic         req_dec,
    input  logic         req_key_reuse,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [127:0] res_data,
    output logic         initiate,
    output logic         RW,
    output logic         adress,
    output logic [31:0]  data_out,
    output logic         data_oe,
    input  logic [31:0]  data_in,
    output logic         selCypher,
    output logic         start,
    output logic         busy
);

    localparam int WAIT_W = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;

    state_t              state_reg, state_next;
    logic                ready_en_reg;
    logic [127:0]        key_reg, msg_reg;
    logic                dec_reg, reuse_reg;
    logic [WAIT_W-1:0]   wait_reg, wait_next;
    logic [1:0]          rd_idx_reg, rd_idx_next;
    logic                strobe_done_reg, strobe_done_next;
    logic                strobe;
    logic [READ_LAT-1:0]      pend_pipe_reg;
    logic [READ_LAT-1:0][1:0] idx_pipe_reg;
    logic                cap_en;
    logic [1:0]          cap_idx;
    logic                ser_en, ser_last;
    logic [31:0]         ser_word;
    logic [127:0]        ser_block;
    logic                accept;

    assign accept    = req_valid && req_ready;
    assign cap_en    = pend_pipe_reg[READ_LAT-1];
    assign cap_idx   = idx_pipe_reg[READ_LAT-1];
    assign ser_block = (state_reg == WR_KEY) ? key_reg : msg_reg;

    aes_word_serializer u_ser (
        .clk   (clk),
        .reset (reset),
        .en    (ser_en),
        .block (ser_block),
        .word  (ser_word),
        .last  (ser_last)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg       <= IDLE;
            ready_en_reg    <= 1'b0;
            wait_reg        <= '0;
            rd_idx_reg      <= '0;
            strobe_done_reg <= 1'b0;
            key_reg         <= '0;
            msg_reg         <= '0;
            dec_reg         <= 1'b0;
            reuse_reg       <= 1'b0;
        end else begin
            state_reg       <= state_next;
            ready_en_reg    <= 1'b1;
            wait_reg        <= wait_next;
            rd_idx_reg      <= rd_idx_next;
            strobe_done_reg <= strobe_done_next;
            if (accept) begin
                key_reg   <= req_key;
                msg_reg   <= req_msg;
                dec_reg   <= req_dec;
                reuse_reg <= req_key_reuse;
            end
        end
    end

    // Read strobes are tracked through a READ_LAT-deep pipe so each word is
    // captured exactly when the chip presents it.
    if (READ_LAT == 1) begin : g_lat1
        always_ff @(posedge clk) begin
            if (!reset) begin
                pend_pipe_reg <= '0;
                idx_pipe_reg  <= '0;
            end else begin
                pend_pipe_reg[0] <= strobe;
                idx_pipe_reg[0]  <= rd_idx_reg;
            end
        end
    end else begin : g_latn
        always_ff @(posedge clk) begin
            if (!reset) begin
                pend_pipe_reg <= '0;
                idx_pipe_reg  <= '0;
            end else begin
                pend_pipe_reg <= {pend_pipe_reg[READ_LAT-2:0], strobe};
                idx_pipe_reg  <= {idx_pipe_reg[READ_LAT-2:0], rd_idx_reg};
            end
        end
    end

    for (genvar gi = 0; gi < WORDS_PER_BLOCK; gi++) begin : g_res
        logic [31:0] word_reg;
        always_ff @(posedge clk) begin
            if (!reset) begin
                word_reg <= '0;
            end else if (cap_en && (cap_idx == 2'(gi))) begin
                word_reg <= data_in;
            end
        end
        assign res_data[127-32*gi -: 32] = word_reg;
    end

    always_comb begin
        state_next       = state_reg;
        wait_next        = wait_reg;
        rd_idx_next      = rd_idx_reg;
        strobe_done_next = strobe_done_reg;
        ser_en           = 1'b0;
        strobe           = 1'b0;
        req_ready        = 1'b0;
        res_valid        = 1'b0;
        initiate         = 1'b0;
        RW               = RW_WRITE;
        adress           = ADR_MSG;
        data_out         = '0;
        data_oe          = 1'b0;
        start            = 1'b0;
        selCypher        = 1'b0;
        busy             = (state_reg != IDLE);
        case (state_reg)
            IDLE: begin
                req_ready = ready_en_reg;
                if (req_valid && ready_en_reg) state_next = INIT;
            end
            INIT: begin
                initiate   = 1'b1;
                state_next = reuse_reg ? WR_MSG : WR_KEY;
            end
            WR_KEY: begin
                ser_en   = 1'b1;
                adress   = ADR_KEY;
                data_oe  = 1'b1;
                data_out = ser_word;
                if (ser_last) state_next = WR_MSG;
            end
            WR_MSG: begin
                ser_en   = 1'b1;
                data_oe  = 1'b1;
                data_out = ser_word;
                if (ser_last) state_next = START;
            end
            START: begin
                start      = 1'b1;
                selCypher  = dec_reg;
                wait_next  = '0;
                state_next = WAIT;
            end
            WAIT: begin
                selCypher = dec_reg;
                if (wait_reg == WAIT_W'(CORE_LAT - 1)) begin
                    wait_next  = '0;
                    state_next = READ;
                end else begin
                    wait_next = wait_reg + WAIT_W'(1);
                end
            end
            READ: begin
                selCypher = dec_reg;
                if (!strobe_done_reg) begin
                    strobe      = 1'b1;
                    RW          = RW_READ;
                    rd_idx_next = rd_idx_reg + 2'd1;
                    if (rd_idx_reg == 2'(WORDS_PER_BLOCK - 1)) strobe_done_next = 1'b1;
                end
                if (cap_en && (cap_idx == 2'(WORDS_PER_BLOCK - 1))) begin
                    strobe_done_next = 1'b0;
                    state_next       = RESP;
                end
            end
            RESP: begin
                res_valid = 1'b1;
                if (res_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_aes_bus_master.sv
// Scoreboard bench for aes_bus_master with a behavioural AES128 chip model
// that knows the FIPS-197 C.1 pair and falls back to key^msg^{dec}.
module tb_aes_bus_master;

    localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P0 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] M3 = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] M3_INV = 128'hfedcba98765432100123456789abcdef;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid, req_ready;
    logic [127:0] req_key, req_msg;
    logic         req_dec, req_key_reuse;
    logic         res_valid, res_ready;
    logic [127:0] res_data;
    logic         initiate, RW, adress, data_oe, selCypher, start, busy;
    logic [31:0]  data_out;
    logic [31:0]  data_in = '0;

    aes_bus_master dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_key       (req_key),
        .req_msg       (req_msg),
        .req_dec       (req_dec),
        .req_key_reuse (req_key_reuse),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_data      (res_data),
        .initiate      (initiate),
        .RW            (RW),
        .adress        (adress),
        .data_out      (data_out),
        .data_oe       (data_oe),
        .data_in       (data_in),
        .selCypher     (selCypher),
        .start         (start),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- chip model ----------------
    logic [31:0]  ck [4];
    logic [31:0]  cm [4];
    logic [1:0]   kp = '0, mp = '0, rp = '0;
    logic [127:0] cres = '0;

    function automatic logic [127:0] chip_fn(input logic [127:0] k, input logic [127:0] m, input logic d);
        if (k == K0 && m == P0 && !d) return C0;
        if (k == K0 && m == C0 && d)  return P0;
        return k ^ m ^ {128{d}};
    endfunction

    always @(posedge clk) begin
        if (initiate) begin
            kp <= '0;
            mp <= '0;
            rp <= '0;
        end else if (data_oe && RW) begin
            if (adress) begin
                ck[kp] <= data_out;
                kp     <= kp + 2'd1;
            end else begin
                cm[mp] <= data_out;
                mp     <= mp + 2'd1;
            end
        end else if (!RW) begin
            data_in <= cres[127-32*rp -: 32];
            rp      <= rp + 2'd1;
        end
        if (start)
            cres <= chip_fn({ck[0], ck[1], ck[2], ck[3]}, {cm[0], cm[1], cm[2], cm[3]}, selCypher);
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [127:0] res;
        int           lat;
        int           st;
        int           kw;
        logic         dec;
    } exp_t;
    exp_t sb[$];

    int           cyc = 0;
    int           hs_cyc = 0;
    int           kw = 0, mw = 0;
    int           n_txn = 0;
    logic         stalled = 1'b0;
    logic [127:0] snap = '0;

    // Edge-side monitor: handshakes, bus writes, result transfers, stall stability.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!reset) begin
            stalled <= 1'b0;
        end else begin
            if (req_valid && req_ready) begin
                hs_cyc <= cyc;
                kw     <= 0;
                mw     <= 0;
            end
            if (data_oe && RW && adress)  kw <= kw + 1;
            if (data_oe && RW && !adress) mw <= mw + 1;
            if (res_valid && !res_ready) begin
                if (stalled) begin
                    chk("stall_res_data", res_data, snap);
                    chk("stall_req_ready", 128'(req_ready), 128'(0));
                end
                snap    <= res_data;
                stalled <= 1'b1;
            end else begin
                stalled <= 1'b0;
            end
            if (res_valid && res_ready && sb.size() > 0) begin
                chk("res_data", res_data, sb[0].res);
                n_txn++;
                $display("txn %0d: result %h", n_txn, res_data);
                void'(sb.pop_front());
            end
        end
    end

    logic prev_rv = 1'b0, prev_init = 1'b0, prev_start = 1'b0;

    // Level-side monitor: pulse widths, bus discipline, start/latency timing.
    // cyc - hs_cyc is the cycle number counting the cycle after the handshake edge as 1.
    always @(negedge clk) begin
        if (data_oe) chk("oe_implies_write", 128'(RW), 128'(1));
        if (prev_init)  chk("initiate_width", 128'(initiate), 128'(0));
        if (prev_start) chk("start_width", 128'(start), 128'(0));
        if (reset && start && !prev_start && sb.size() > 0) begin
            chk("start_cycle", 128'(cyc - hs_cyc), 128'(sb[0].st));
            chk("key_writes", 128'(kw), 128'(sb[0].kw));
            chk("msg_writes", 128'(mw), 128'(4));
            chk("selCypher", 128'(selCypher), 128'(sb[0].dec));
        end
        if (reset && res_valid && !prev_rv) begin
            if (sb.size() == 0) begin
                chk("unexpected_res_valid", 128'(res_valid), 128'(0));
            end else begin
                chk("res_latency", 128'(cyc - hs_cyc - 1), 128'(sb[0].lat));
            end
        end
        prev_rv    = res_valid;
        prev_init  = initiate;
        prev_start = start;
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [127:0] k, input logic [127:0] m, input logic d, input logic r,
                        input logic push, input logic [127:0] er, input int el, input int es, input int ekw);
        int n = 0;
        exp_t e;
        while (req_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            chk("req_ready_timeout", 128'(req_ready), 128'(1));
            return;
        end
        req_key       = k;
        req_msg       = m;
        req_dec       = d;
        req_key_reuse = r;
        req_valid     = 1'b1;
        if (push) begin
            e.res = er; e.lat = el; e.st = es; e.kw = ekw; e.dec = d;
            sb.push_back(e);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        @(negedge clk);
        while ((sb.size() != 0 || busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk("done_timeout", 128'(sb.size()), 128'(0));
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk(nm, {res_data, data_out,
                 req_ready, res_valid, initiate, RW, adress, data_oe, selCypher, start, busy},
            {128'h0, 32'h0, 9'b000100000});
    endtask

    initial begin
        int n;
        reset = 1'b0; req_valid = 1'b0; req_key = '0; req_msg = '0;
        req_dec = 1'b0; req_key_reuse = 1'b0; res_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset_outputs");
        reset = 1'b1;

        // FIPS-197 C.1 encrypt with key load
        send(K0, P0, 1'b0, 1'b0, 1'b1, C0, 27, 10, 4);
        wait_done();

        // decrypt reusing the key already in the chip; the offered key must be ignored
        send({128{1'b1}}, C0, 1'b1, 1'b1, 1'b1, P0, 23, 6, 0);
        wait_done();

        // backpressure: hold res_ready low for 10 cycles after res_valid
        res_ready = 1'b0;
        send(128'h0, M3, 1'b0, 1'b0, 1'b1, M3, 27, 10, 4);
        n = 0;
        while (!res_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("bp_res_valid_seen", 128'(res_valid), 128'(1));
        repeat (10) @(negedge clk);
        chk("bp_still_valid", 128'(res_valid), 128'(1));
        res_ready = 1'b1;
        @(negedge clk);
        chk("bp_accept_first_ready", 128'(res_valid), 128'(0));
        wait_done();

        // reset during WAIT aborts the transaction silently
        send(K0, P0, 1'b0, 1'b0, 1'b0, '0, 0, 0, 0);
        n = 0;
        while (!start && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("abort_start_seen", 128'(start), 128'(1));
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_reset_outputs("mid_reset_outputs");
        reset = 1'b1;
        repeat (30) @(negedge clk);
        chk("abort_no_result", 128'(res_valid), 128'(0));
        send(128'h0, M3, 1'b1, 1'b0, 1'b1, M3_INV, 27, 10, 4);
        wait_done();

        // request pulsed while writing the message is ignored
        send(K0, P0, 1'b0, 1'b0, 1'b1, C0, 27, 10, 4);
        n = 0;
        while (!(data_oe && !adress) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("busy_in_wr_msg", {126'h0, req_ready, busy}, {126'h0, 1'b0, 1'b1});
        req_key = {128{1'b1}};
        req_msg = '0;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        wait_done();
        repeat (40) @(negedge clk);
        chk("no_extra_txn", 128'(busy), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
